// File: rtl/broadcast_n.sv
// N-way stream fan-out: one input stream copied into per-output elastic FIFOs,
// with an output-enable mask that is latched at frame start.
module broadcast_n #(
  parameter int unsigned W_DATA  = 16,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_OUT-1:0]          out_en,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic [W_DATA-1:0]           din_data,
  input  logic [1:0]                  din_eot,
  output logic [NUM_OUT-1:0]          dout_valid,
  input  logic [NUM_OUT-1:0]          dout_ready,
  output logic [NUM_OUT*W_DATA-1:0]   dout_data,
  output logic [NUM_OUT*2-1:0]        dout_eot,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = W_DATA + 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_OUT-1:0]   act_mask_q, act_mask_d;
  logic [PW-1:0]        wr_ptr_q [NUM_OUT];
  logic [PW-1:0]        wr_ptr_d [NUM_OUT];
  logic [PW-1:0]        rd_ptr_q [NUM_OUT];
  logic [PW-1:0]        rd_ptr_d [NUM_OUT];
  logic [EW-1:0]        mem_q    [NUM_OUT][DEPTH];
  logic [EW-1:0]        mem_d    [NUM_OUT][DEPTH];

  logic [NUM_OUT-1:0]   mask_use;
  logic [NUM_OUT-1:0]   full;
  logic [NUM_OUT-1:0]   empty;
  logic [NUM_OUT-1:0]   push;
  logic [NUM_OUT-1:0]   pop;
  logic                 accept;

  // FIFO status and handshake; din_ready depends only on registered FIFO state and the mask
  always_comb begin
    mask_use = (state_q == IDLE) ? out_en : act_mask_q;
    full     = '0;
    empty    = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                 (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
    end
    din_ready = &(~mask_use | ~full);
    accept    = din_valid & din_ready;
    push      = {NUM_OUT{accept}} & mask_use;
    pop       = ~empty & dout_ready;
  end

  // Frame tracking: mask is captured on the first accepted beat of each frame
  always_comb begin
    state_d    = state_q;
    act_mask_d = act_mask_q;
    if (accept) begin
      if (state_q == IDLE) begin
        act_mask_d = out_en;
      end
      state_d = (din_eot == 2'b11) ? IDLE : FRAME;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = {din_eot, din_data};
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
    end
  end

  // Outputs come straight from the FIFO heads; zeroed while a FIFO is empty
  always_comb begin
    dout_valid = ~empty;
    dout_data  = '0;
    dout_eot   = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (!empty[i]) begin
        dout_data[i*W_DATA +: W_DATA] = mem_q[i][rd_ptr_q[i][AW-1:0]][W_DATA-1:0];
        dout_eot[i*2 +: 2]            = mem_q[i][rd_ptr_q[i][AW-1:0]][W_DATA +: 2];
      end
    end
    busy = (state_q == FRAME) | ~(&empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      act_mask_q <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      act_mask_q <= act_mask_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible when the pointers say so
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_broadcast_n.sv
// Directed bench for broadcast_n (W_DATA=16, NUM_OUT=3, DEPTH=4).
module tb_broadcast_n;

  logic        clk;
  logic        rst;
  logic [2:0]  out_en;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din_data;
  logic [1:0]  din_eot;
  logic [2:0]  dout_valid;
  logic [2:0]  dout_ready;
  logic [47:0] dout_data;
  logic [5:0]  dout_eot;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];
  int t0[$];

  broadcast_n #(.W_DATA(16), .NUM_OUT(3), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_en     (out_en),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_eot    (din_eot),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_eot   (dout_eot),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat popped from each output as {eot,data}
  always @(posedge clk) begin
    if (!rst) begin
      if (dout_valid[0] && dout_ready[0]) begin
        q0.push_back({dout_eot[1:0], dout_data[15:0]});
        t0.push_back(cyc);
      end
      if (dout_valid[1] && dout_ready[1]) q1.push_back({dout_eot[3:2], dout_data[31:16]});
      if (dout_valid[2] && dout_ready[2]) q2.push_back({dout_eot[5:4], dout_data[47:32]});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int o);
    case (o)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [17:0] qget(input int o, input int k);
    if (k >= qsize(o)) return 18'h3ffff;
    case (o)
      0:       return q0[k];
      1:       return q1[k];
      default: return q2[k];
    endcase
  endfunction

  // Check n consecutive beats base..base+n-1 starting at entry off; last beat carries eot=11
  task automatic chk_out(input int o, input int off, input logic [15:0] base, input int n);
    logic [17:0] e;
    for (int k = 0; k < n; k++) begin
      e = {(k == n - 1) ? 2'b11 : 2'b00, 16'(base + 16'(k))};
      chk($sformatf("out%0d_beat%0d", o, off + k), 64'(qget(o, off + k)), 64'(e));
    end
  endtask

  task automatic clr_q();
    q0.delete();
    q1.delete();
    q2.delete();
    t0.delete();
  endtask

  // Present one beat and hold it until accepted (bounded wait)
  task automatic send_beat(input logic [15:0] d, input logic [1:0] e);
    int n;
    n = 0;
    din_valid = 1'b1;
    din_data  = d;
    din_eot   = e;
    while (!din_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) chk("send_timeout", 64'(din_ready), 64'(1));
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    out_en     = 3'b111;
    din_valid  = 1'b0;
    din_data   = '0;
    din_eot    = '0;
    dout_ready = 3'b111;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(dout_valid), 64'(0));
    chk("rst_data",  64'(dout_data),  64'(0));
    chk("rst_eot",   64'(dout_eot),   64'(0));
    chk("rst_busy",  64'(busy),       64'(0));
    rst = 1'b0;
    chk("rst_ready", 64'(din_ready),  64'(1));
    @(negedge clk);

    // 1: all outputs ready, 10-beat frame
    clr_q();
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("t1_ready%0d", k), 64'(din_ready), 64'(1));
      send_beat(16'(k), (k == 10) ? 2'b11 : 2'b00);
      if (k == 1) begin
        chk("t1_lat_valid", 64'(dout_valid), 64'(3'b111));
        chk("t1_lat_data",  64'(dout_data),  64'({16'd1, 16'd1, 16'd1}));
      end
    end
    repeat (4) @(negedge clk);
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("t1_cnt%0d", o), 64'(qsize(o)), 64'(10));
      chk_out(o, 0, 16'd1, 10);
    end
    if (t0.size() == 10) chk("t1_rate", 64'(t0[9] - t0[0]), 64'(9));
    chk("t1_busy", 64'(busy), 64'(0));

    // 2: output 1 stalled, FIFO 1 fills and back-pressures
    clr_q();
    dout_ready = 3'b101;
    for (int k = 1; k <= 4; k++) send_beat(16'(k), 2'b00);
    din_valid = 1'b1;
    din_data  = 16'd5;
    din_eot   = 2'b00;
    chk("t2_block", 64'(din_ready), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_ready", 64'(din_ready),          64'(0));
      chk("t2_hold_valid", 64'(dout_valid[1]),      64'(1));
      chk("t2_hold_data",  64'(dout_data[31:16]),   64'(1));
    end
    chk("t2_cnt0", 64'(qsize(0)), 64'(4));
    chk("t2_cnt2", 64'(qsize(2)), 64'(4));
    chk("t2_cnt1", 64'(qsize(1)), 64'(0));
    dout_ready = 3'b111;
    chk("t2_still_block", 64'(din_ready), 64'(0));
    @(negedge clk);
    chk("t2_resume", 64'(din_ready), 64'(1));
    for (int k = 5; k <= 10; k++) send_beat(16'(k), (k == 10) ? 2'b11 : 2'b00);
    repeat (8) @(negedge clk);
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("t2_cnt_end%0d", o), 64'(qsize(o)), 64'(10));
      chk_out(o, 0, 16'd1, 10);
    end

    // 3: mask change mid-frame only takes effect on the next frame
    clr_q();
    out_en = 3'b111;
    send_beat(16'h0011, 2'b00);
    send_beat(16'h0012, 2'b00);
    out_en = 3'b001;
    send_beat(16'h0013, 2'b00);
    send_beat(16'h0014, 2'b11);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_off%0d", k), 64'(dout_valid[2:1]), 64'(0));
      send_beat(16'(16'h0021 + 16'(k)), (k == 4) ? 2'b11 : 2'b00);
    end
    chk("t3_off_end", 64'(dout_valid[2:1]), 64'(0));
    repeat (3) @(negedge clk);
    chk("t3_cnt0", 64'(qsize(0)), 64'(9));
    chk("t3_cnt1", 64'(qsize(1)), 64'(4));
    chk("t3_cnt2", 64'(qsize(2)), 64'(4));
    for (int o = 0; o < 3; o++) chk_out(o, 0, 16'h0011, 4);
    chk_out(0, 4, 16'h0021, 5);

    // 4: sink mode, all outputs disabled
    clr_q();
    out_en = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t4_ready%0d", k), 64'(din_ready),  64'(1));
      chk($sformatf("t4_valid%0d", k), 64'(dout_valid), 64'(0));
      send_beat(16'(16'h0100 + 16'(k)), (k == 8) ? 2'b11 : 2'b00);
      if (k == 1) chk("t4_busy_mid", 64'(busy), 64'(1));
    end
    chk("t4_valid_end", 64'(dout_valid), 64'(0));
    chk("t4_busy_end",  64'(busy),       64'(0));
    chk("t4_cnt", 64'(qsize(0) + qsize(1) + qsize(2)), 64'(0));

    // 5: asynchronous reset mid-frame with FIFO levels 3/1/2
    out_en     = 3'b111;
    dout_ready = 3'b000;
    send_beat(16'h0031, 2'b00);
    send_beat(16'h0032, 2'b00);
    send_beat(16'h0033, 2'b00);
    dout_ready = 3'b110;
    @(negedge clk);
    dout_ready = 3'b010;
    @(negedge clk);
    dout_ready = 3'b000;
    chk("t5_valid_pre", 64'(dout_valid),        64'(3'b111));
    chk("t5_busy_pre",  64'(busy),              64'(1));
    chk("t5_head0",     64'(dout_data[15:0]),   64'(16'h0031));
    chk("t5_head1",     64'(dout_data[31:16]),  64'(16'h0033));
    chk("t5_head2",     64'(dout_data[47:32]),  64'(16'h0032));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid_rst", 64'(dout_valid), 64'(0));
    chk("t5_busy_rst",  64'(busy),       64'(0));
    chk("t5_data_rst",  64'(dout_data),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    chk("t5_ready_rel", 64'(din_ready), 64'(1));
    clr_q();
    dout_ready = 3'b111;
    send_beat(16'h0041, 2'b00);
    send_beat(16'h0042, 2'b00);
    send_beat(16'h0043, 2'b11);
    repeat (4) @(negedge clk);
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("t5_cnt%0d", o), 64'(qsize(o)), 64'(3));
      chk_out(o, 0, 16'h0041, 3);
    end

    // 6: single-beat frame from IDLE
    clr_q();
    send_beat(16'h00AB, 2'b11);
    chk("t6_valid", 64'(dout_valid), 64'(3'b111));
    chk("t6_eot",   64'(dout_eot),   64'(6'b111111));
    chk("t6_busy",  64'(busy),       64'(1));
    repeat (3) @(negedge clk);
    chk("t6_idle", 64'(busy), 64'(0));
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("t6_cnt%0d", o), 64'(qsize(o)), 64'(1));
      chk_out(o, 0, 16'h00AB, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
